// File: rtl/l2_storage_bank.sv
// l2_storage_bank: storage core of the 4-way L2 cache.
// Holds per-way valid/dirty/tag arrays, per-set pseudo-LRU bits, per-way
// byte-writable line data arrays and a fill line buffer. All array reads are
// set-indexed and registered (1-cycle latency) with write-through forwarding
// when the same set is written in the read cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   rindex / windex    read / write set index
//   v_*  / d_*         per-way valid / dirty bit load, data in, data out
//   tag_*              per-way tag load, shared tag in, packed per-way tags out
//   lru_*              per-set pseudo-LRU load, data in, data out
//   data_*             per-way byte enables, write lines, read lines
//   buf_*              line buffer load, line in, line out
module l2_storage_bank #(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_index  = 3,
  parameter int unsigned s_tag    = 32 - s_offset - s_index,
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_mask   = 2**s_offset,
  parameter int unsigned s_line   = 8*s_mask
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [s_index-1:0]           rindex,
  input  logic [s_index-1:0]           windex,
  input  logic [num_ways-1:0]          v_load,
  input  logic [num_ways-1:0]          v_datain,
  output logic [num_ways-1:0]          v_dataout,
  input  logic [num_ways-1:0]          d_load,
  input  logic [num_ways-1:0]          d_datain,
  output logic [num_ways-1:0]          d_dataout,
  input  logic [num_ways-1:0]          tag_load,
  input  logic [s_tag-1:0]             tag_datain,
  output logic [num_ways*s_tag-1:0]    tag_dataout,
  input  logic                         lru_load,
  input  logic [num_ways-2:0]          lru_datain,
  output logic [num_ways-2:0]          lru_dataout,
  input  logic [num_ways*s_mask-1:0]   data_write_en,
  input  logic [num_ways*s_line-1:0]   data_datain,
  output logic [num_ways*s_line-1:0]   data_dataout,
  input  logic                         buf_load,
  input  logic [s_line-1:0]            buf_in,
  output logic [s_line-1:0]            buf_out
);

  localparam int unsigned num_sets = 2**s_index;

  logic [num_ways-1:0] valid_mem [num_sets];
  logic [num_ways-1:0] dirty_mem [num_sets];
  logic [s_tag-1:0]    tag_mem   [num_ways][num_sets];
  logic [num_ways-2:0] lru_mem   [num_sets];
  logic [s_line-1:0]   data_mem  [num_ways][num_sets];

  logic same_set_c;
  assign same_set_c = (rindex == windex);

  // Metadata arrays: reset clears contents and outputs, reset beats a load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(num_sets); s++) begin
        valid_mem[s] <= '0;
        dirty_mem[s] <= '0;
        lru_mem[s]   <= '0;
        for (int w = 0; w < int'(num_ways); w++) begin
          tag_mem[w][s] <= '0;
        end
      end
      v_dataout   <= '0;
      d_dataout   <= '0;
      tag_dataout <= '0;
      lru_dataout <= '0;
    end else begin
      for (int w = 0; w < int'(num_ways); w++) begin
        v_dataout[w] <= (v_load[w] && same_set_c) ? v_datain[w] : valid_mem[rindex][w];
        d_dataout[w] <= (d_load[w] && same_set_c) ? d_datain[w] : dirty_mem[rindex][w];
        tag_dataout[w*s_tag +: s_tag] <= (tag_load[w] && same_set_c) ? tag_datain
                                                                      : tag_mem[w][rindex];
        if (v_load[w])   valid_mem[windex][w] <= v_datain[w];
        if (d_load[w])   dirty_mem[windex][w] <= d_datain[w];
        if (tag_load[w]) tag_mem[w][windex]   <= tag_datain;
      end
      lru_dataout <= (lru_load && same_set_c) ? lru_datain : lru_mem[rindex];
      if (lru_load) lru_mem[windex] <= lru_datain;
    end
  end

  // Line contents are never reset, so byte writes proceed even during reset.
  always_ff @(posedge clk) begin
    for (int w = 0; w < int'(num_ways); w++) begin
      for (int b = 0; b < int'(s_mask); b++) begin
        if (data_write_en[w*s_mask + b]) begin
          data_mem[w][windex][b*8 +: 8] <= data_datain[w*s_line + b*8 +: 8];
        end
      end
    end
  end

  // Line read register with byte-granular forwarding of same-set writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_dataout <= '0;
    end else begin
      for (int w = 0; w < int'(num_ways); w++) begin
        for (int b = 0; b < int'(s_mask); b++) begin
          data_dataout[w*s_line + b*8 +: 8] <=
            (data_write_en[w*s_mask + b] && same_set_c) ? data_datain[w*s_line + b*8 +: 8]
                                                        : data_mem[w][rindex][b*8 +: 8];
        end
      end
    end
  end

  // Fill line buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_out <= '0;
    end else if (buf_load) begin
      buf_out <= buf_in;
    end
  end

endmodule

// File: tb/tb_l2_storage_bank.sv
// Directed self-checking bench for l2_storage_bank.
module tb_l2_storage_bank;

  logic           clk = 1'b0;
  logic           rst;
  logic [2:0]     rindex, windex;
  logic [3:0]     v_load, v_datain, v_dataout;
  logic [3:0]     d_load, d_datain, d_dataout;
  logic [3:0]     tag_load;
  logic [23:0]    tag_datain;
  logic [95:0]    tag_dataout;
  logic           lru_load;
  logic [2:0]     lru_datain, lru_dataout;
  logic [127:0]   data_write_en;
  logic [1023:0]  data_datain, data_dataout;
  logic           buf_load;
  logic [255:0]   buf_in, buf_out;

  int checks = 0;
  int errors = 0;

  l2_storage_bank dut (
    .clk(clk), .rst(rst), .rindex(rindex), .windex(windex),
    .v_load(v_load), .v_datain(v_datain), .v_dataout(v_dataout),
    .d_load(d_load), .d_datain(d_datain), .d_dataout(d_dataout),
    .tag_load(tag_load), .tag_datain(tag_datain), .tag_dataout(tag_dataout),
    .lru_load(lru_load), .lru_datain(lru_datain), .lru_dataout(lru_dataout),
    .data_write_en(data_write_en), .data_datain(data_datain), .data_dataout(data_dataout),
    .buf_load(buf_load), .buf_in(buf_in), .buf_out(buf_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [255:0] l11, l22, l33, l44, exp1, b1;

  initial begin
    rst = 1'b1; rindex = '0; windex = '0;
    v_load = '0; v_datain = '0; d_load = '0; d_datain = '0;
    tag_load = '0; tag_datain = '0; lru_load = 1'b0; lru_datain = '0;
    data_write_en = '0; data_datain = '0; buf_load = 1'b0; buf_in = '0;
    l11 = {32{8'h11}}; l22 = {32{8'h22}}; l33 = {32{8'h33}}; l44 = {32{8'h44}};
    b1  = {8{32'hDEADBEEF}};

    // Reset state
    step();
    rst = 1'b0;
    check("rst_v", 1024'(v_dataout), '0);
    check("rst_d", 1024'(d_dataout), '0);
    check("rst_tag", 1024'(tag_dataout), '0);
    check("rst_lru", 1024'(lru_dataout), '0);
    check("rst_buf", 1024'(buf_out), '0);
    check("rst_data", data_dataout, '0);
    for (int s = 0; s < 8; s++) begin
      rindex = 3'(s);
      step();
      check("rst_set_meta", 1024'({v_dataout, d_dataout, tag_dataout, lru_dataout}), '0);
    end

    // Tag and valid write to set 3 way 2
    windex = 3'd3; rindex = 3'd0;
    tag_load = 4'b0100; tag_datain = 24'hABCDEF;
    v_load = 4'b0100; v_datain = 4'b0100;
    step();
    tag_load = '0; v_load = '0; v_datain = '0;
    rindex = 3'd3;
    step();
    check("tag_set3", 1024'(tag_dataout), 1024'(96'h000000_ABCDEF_000000_000000));
    check("v_set3", 1024'(v_dataout), 1024'(4'b0100));
    rindex = 3'd2;
    step();
    check("tag_set2", 1024'(tag_dataout), '0);
    check("v_set2", 1024'(v_dataout), '0);

    // Same-edge forwarding of LRU and dirty writes
    rindex = 3'd5; windex = 3'd5;
    lru_load = 1'b1; lru_datain = 3'b101;
    d_load = 4'b0010; d_datain = 4'b0010;
    step();
    check("lru_fwd", 1024'(lru_dataout), 1024'(3'b101));
    check("d_fwd", 1024'(d_dataout), 1024'(4'b0010));
    lru_load = 1'b0; lru_datain = '0; d_load = '0; d_datain = '0;
    step();
    check("lru_stored", 1024'(lru_dataout), 1024'(3'b101));
    check("d_stored", 1024'(d_dataout), 1024'(4'b0010));

    // Full-line fill of set 6 on all ways
    windex = 3'd6; rindex = 3'd0;
    data_write_en = '1;
    data_datain = {l44, l33, l11, l22};
    step();
    // Partial write: way1 low 2 bytes only; other ways carry junk with no enables
    data_write_en = '0;
    data_write_en[63:32] = 32'h0000_0003;
    data_datain = {{256{1'b1}}, {256{1'b1}}, {240'h0, 16'hAAAA}, {256{1'b1}}};
    step();
    data_write_en = '0; data_datain = '0;
    rindex = 3'd6;
    step();
    exp1 = {l11[255:16], 16'hAAAA};
    check("data_w0", 1024'(data_dataout[255:0]), 1024'(l22));
    check("data_w1", 1024'(data_dataout[511:256]), 1024'(exp1));
    check("data_w2", 1024'(data_dataout[767:512]), 1024'(l33));
    check("data_w3", 1024'(data_dataout[1023:768]), 1024'(l44));
    // Byte-granular forwarding: way1 byte 2 written while reading set 6
    data_write_en[34] = 1'b1;
    data_datain[256+16 +: 8] = 8'h55;
    step();
    data_write_en = '0; data_datain = '0;
    exp1 = {l11[255:24], 8'h55, 16'hAAAA};
    check("data_fwd_w1", 1024'(data_dataout[511:256]), 1024'(exp1));
    check("data_fwd_w0", 1024'(data_dataout[255:0]), 1024'(l22));
    step();
    check("data_after_fwd_w1", 1024'(data_dataout[511:256]), 1024'(exp1));

    // Line buffer load and hold
    buf_load = 1'b1; buf_in = b1;
    step();
    check("buf_load", 1024'(buf_out), 1024'(b1));
    buf_load = 1'b0; buf_in = ~b1;
    step();
    check("buf_hold", 1024'(buf_out), 1024'(b1));

    // Reset priority over simultaneous loads; line writes still land
    rst = 1'b1; rindex = 3'd0; windex = 3'd0;
    v_load = 4'b1111; v_datain = 4'b1111;
    buf_load = 1'b1; buf_in = b1;
    step();
    rst = 1'b0; v_load = '0; v_datain = '0; buf_load = 1'b0; buf_in = '0;
    check("rstp_v", 1024'(v_dataout), '0);
    check("rstp_buf", 1024'(buf_out), '0);
    check("rstp_data", data_dataout, '0);
    check("rstp_lru", 1024'(lru_dataout), '0);
    step();
    check("rstp_v_mem", 1024'(v_dataout), '0);
    rindex = 3'd5;
    step();
    check("rstp_lru_mem", 1024'(lru_dataout), '0);
    check("rstp_d_mem", 1024'(d_dataout), '0);

    // Data write during reset: way0 set 7 byte 0
    rst = 1'b1; windex = 3'd7; rindex = 3'd0;
    data_write_en = '0; data_write_en[0] = 1'b1;
    data_datain = '0; data_datain[7:0] = 8'h77;
    step();
    rst = 1'b0; data_write_en = '0; data_datain = '0;
    rindex = 3'd7;
    step();
    check("rst_data_write", 1024'(data_dataout[7:0]), 1024'(8'h77));
    rindex = 3'd6;
    step();
    check("data_survives_rst", 1024'(data_dataout[511:256]), 1024'(exp1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_storage_bank.md
Name: l2_storage_bank

Overview:
- Storage core of the 4-way L2 cache: per-way valid, dirty and tag arrays, per-set pseudo-LRU bits, per-way byte-writable line data arrays, and a line buffer register that captures fill data from physical memory.
- Contains no hit/miss, distance or replacement logic; the cache datapath and controller drive it.
- All arrays use set-indexed, registered reads (1-cycle latency).

Parameters:
- s_offset, 5, byte-offset bits; s_mask = 2**s_offset bytes per line (32).
- s_index, 3, set-index bits; num_sets = 2**s_index (8).
- s_tag, 32-s_offset-s_index, tag width (24).
- num_ways, 4, ways per set; LRU width is num_ways-1 (3).
- s_line, 8*s_mask, line width in bits (256).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- rindex  in  s_index  set being read.
- windex  in  s_index  set being written.
- v_load  in  num_ways  per-way valid write enable.
- v_datain  in  num_ways  per-way valid bit to write.
- v_dataout  out  num_ways  per-way valid bit.
- d_load, d_datain, d_dataout  as v_*  dirty bits.
- tag_load  in  num_ways  per-way tag write enable.
- tag_datain  in  s_tag  tag to write, shared by all ways.
- tag_dataout  out  num_ways*s_tag  way w occupies bits [w*s_tag +: s_tag].
- lru_load  in  1  LRU write enable.
- lru_datain  in  num_ways-1  LRU bits to write.
- lru_dataout  out  num_ways-1  LRU bits.
- data_write_en  in  num_ways*s_mask  per-way byte enables; way w occupies [w*s_mask +: s_mask].
- data_datain  in  num_ways*s_line  per-way write line.
- data_dataout  out  num_ways*s_line  per-way read line.
- buf_load  in  1  line buffer load enable.
- buf_in  in  s_line  line from physical memory.
- buf_out  out  s_line  line buffer contents.

Behaviour:
- Metadata arrays (valid, dirty, tag, LRU), one storage element per set:
  - rst: every entry and the dataout register clear to 0 on the next edge; rst overrides a simultaneous load.
  - Otherwise, on each edge: dataout <= (load && rindex==windex) ? datain : mem[rindex], i.e. write-through forwarding.
  - Otherwise, on each edge: if load, mem[windex] <= datain.
  - Read latency is 1 cycle. Output reflects rindex as sampled at the previous edge and holds until the next edge.
- Data arrays, one per way, num_sets lines of s_mask bytes:
  - For each byte i with write_en[i]=1: line[windex].byte[i] <= datain.byte[i]. Other bytes are unchanged. Enables all-0 means no write; all-1 means a full-line fill.
  - Read, every edge, per byte: dataout.byte[i] <= (write_en[i] && rindex==windex) ? datain.byte[i] : line[rindex].byte[i]. This is byte-granular forwarding.
  - rst clears the dataout register to 0. Line contents are not reset and are undefined until written. Verification must write a set before checking its reads.
- Line buffer:
  - rst: buf_out <= 0.
  - Else if buf_load: buf_out <= buf_in.
  - Else hold.
  - Output is directly from the register.
- Ways are fully independent. Simultaneous writes to several ways in the same cycle all take effect.
- No address wrap logic is needed: rindex and windex span exactly num_sets entries.
- Reset asserted mid-operation: arrays and buffer clear on that edge. Writes issued in the same cycle are dropped for the metadata arrays and the buffer. Data-array line writes still occur.

Test Plan:
- Reset check: hold rst 1 cycle, then read sets 0..7 -> v/d/tag/lru/buf_out all 0; data_dataout 0 on the first cycle after reset.
- Tag and valid write then read: windex=3, tag_load=4'b0100, tag_datain=24'hABCDEF, v_load/v_datain=4'b0100. Next cycle rindex=3 -> way2 tag ABCDEF with v=1; other ways 0. rindex=2 -> all 0.
- Forwarding: rindex=windex=5, lru_load=1, lru_datain=3'b101 -> lru_dataout=101 after that same edge (no extra cycle).
- Byte-enable write:
  - Fill way1 set 6 with all-1 enables and data 256'h11..11.
  - Then write enables 32'h0000_0003 with data ..AAAA.
  - Read set 6 -> low 2 bytes AA, remaining bytes 11; ways 0/2/3 set 6 unchanged.
- Line buffer: buf_load=1 with buf_in=256'hDEAD..BEEF -> buf_out equals it next cycle. Then buf_load=0 with new buf_in -> buf_out holds the old value.
- Reset priority: assert rst with v_load=4'b1111 at set 0 -> v_dataout reads 0 afterwards.
